// File: rtl/a2d_spi_intf_if.sv
// Handshake and SPI bundle between the motion controller, the A2D SPI
// master and the ADC128S. The master modport is the SPI master's view.
interface a2d_spi_intf_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        a2d_SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport master (
    input  strt_cnv,
    input  chnnl,
    input  MISO,
    output cnv_cmplt,
    output res,
    output a2d_SS_n,
    output SCLK,
    output MOSI
  );

  modport slave (
    output strt_cnv,
    output chnnl,
    output MISO,
    input  cnv_cmplt,
    input  res,
    input  a2d_SS_n,
    input  SCLK,
    input  MOSI
  );
endinterface

// File: rtl/a2d_spi_intf.sv
// SPI master for the ADC128S. One conversion = two 16-bit frames: frame 1
// addresses the channel, frame 2 re-sends the address and returns the
// result of the channel addressed in frame 1. All outputs are registered.
module a2d_spi_intf #(
  parameter int SCLK_DIV = 32,
  parameter int GAP_CLKS = 32
) (
  input logic           clk,
  input logic           rst,
  a2d_spi_intf_if.master bus
);

  localparam int CW = $clog2(SCLK_DIV);
  localparam int GW = $clog2(GAP_CLKS) + 1;
  localparam logic [CW-1:0] CNT_FALL = CW'(SCLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_RISE = CW'(SCLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);
  localparam logic [4:0]    FRAME_BITS = 5'd16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FRAME1 = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_FRAME2 = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rise_q, rise_d;
  logic          fall_seen_q, fall_seen_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   shift_q, shift_d;
  logic          miso_smpl_q, miso_smpl_d;
  logic [2:0]    chnl_lat_q, chnl_lat_d;
  logic          ss_n_q, ss_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cmplt_q, cmplt_d;
  logic [11:0]   res_q, res_d;

  // Next-state logic for the conversion sequencer and SPI framing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rise_d      = rise_q;
    fall_seen_d = fall_seen_q;
    gap_d       = gap_q;
    shift_d     = shift_q;
    miso_smpl_d = miso_smpl_q;
    chnl_lat_d  = chnl_lat_q;
    ss_n_d      = ss_n_q;
    sclk_d      = sclk_q;
    cmplt_d     = cmplt_q;
    res_d       = res_q;
    case (state_q)
      ST_IDLE: begin
        ss_n_d = 1'b1;
        sclk_d = 1'b1;
        if (bus.strt_cnv) begin
          chnl_lat_d  = bus.chnnl;
          cmplt_d     = 1'b0;
          ss_n_d      = 1'b0;
          cnt_d       = {CW{1'b0}};
          rise_d      = 5'd0;
          fall_seen_d = 1'b0;
          shift_d     = {2'b00, bus.chnnl, 11'h000};
          state_d     = ST_FRAME1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FRAME1, ST_FRAME2: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_RISE) begin
          miso_smpl_d = bus.MISO;
          rise_d      = rise_q + 5'd1;
        end else begin
          miso_smpl_d = miso_smpl_q;
        end
        if (cnt_q == CNT_FALL) begin
          // First fall is skipped so the address MSB is valid at the first rise.
          if (fall_seen_q) begin
            shift_d = {shift_q[14:0], miso_smpl_q};
          end else begin
            shift_d = shift_q;
          end
          fall_seen_d = 1'b1;
          if (rise_q == FRAME_BITS) begin
            ss_n_d  = 1'b1;
            cnt_d   = {CW{1'b0}};
            gap_d   = {GW{1'b0}};
            state_d = (state_q == ST_FRAME1) ? ST_GAP : ST_DONE;
          end else begin
            state_d = state_q;
          end
        end else begin
          shift_d = shift_q;
        end
        // Back porch: SCLK stays high once all 16 rises are done.
        if (rise_q == FRAME_BITS) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = ~cnt_d[CW-1];
        end
      end
      ST_GAP: begin
        sclk_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          ss_n_d      = 1'b0;
          cnt_d       = {CW{1'b0}};
          rise_d      = 5'd0;
          fall_seen_d = 1'b0;
          shift_d     = {2'b00, chnl_lat_q, 11'h000};
          state_d     = ST_FRAME2;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_DONE: begin
        res_d   = shift_q[11:0];
        cmplt_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ss_n_d  = 1'b1;
        sclk_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    mosi_d = ss_n_d ? 1'b0 : shift_d[15];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      rise_q      <= 5'd0;
      fall_seen_q <= 1'b0;
      gap_q       <= {GW{1'b0}};
      shift_q     <= 16'h0000;
      miso_smpl_q <= 1'b0;
      chnl_lat_q  <= 3'd0;
      ss_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmplt_q     <= 1'b0;
      res_q       <= 12'h000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rise_q      <= rise_d;
      fall_seen_q <= fall_seen_d;
      gap_q       <= gap_d;
      shift_q     <= shift_d;
      miso_smpl_q <= miso_smpl_d;
      chnl_lat_q  <= chnl_lat_d;
      ss_n_q      <= ss_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cmplt_q     <= cmplt_d;
      res_q       <= res_d;
    end
  end

  assign bus.a2d_SS_n  = ss_n_q;
  assign bus.SCLK      = sclk_q;
  assign bus.MOSI      = mosi_q;
  assign bus.cnv_cmplt = cmplt_q;
  assign bus.res       = res_q;

endmodule

// File: tb/tb_a2d_spi_intf.sv
// Bench for a2d_spi_intf: an ADC128S-like model answers on MISO, a frame
// monitor records MOSI words and SCLK/SS_n timing, and conversions are
// checked from a vector table, hand-written corner sequences and random runs.
module tb_a2d_spi_intf;
  logic clk = 1'b0;
  logic rst;
  a2d_spi_intf_if bus();

  a2d_spi_intf #(.SCLK_DIV(32), .GAP_CLKS(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] mosi;
    int rises;
    int low_len;
    int first_fall;
    int period;
    int gap;
  } frame_t;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] val;
    logic [15:0] exp_mosi;
    logic [11:0] exp_res;
  } vec_t;

  frame_t      frames_q[$];
  logic [11:0] adc_val [8];
  logic [2:0]  prev_addr = 3'd0;
  logic [11:0] model_res = 12'h000;
  int          idle_bad = 0;

  // ADC model + frame monitor state
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b1;
  frame_t      cur;
  logic [15:0] word;
  int          fall_cnt = 0;
  int          high_run = 0;
  int          rise1 = -1;

  // ADC128S model: conversion of the previously addressed channel, 4 leading
  // zeros then 12 data bits, each bit driven on an SCLK fall for the next rise.
  initial begin
    bus.MISO = 1'b0;
    cur = '{mosi: 16'h0000, rises: 0, low_len: 0, first_fall: -1, period: -1, gap: 0};
    forever begin
      @(negedge clk);
      if (bus.a2d_SS_n === 1'b0) begin
        if (prev_ss) begin
          cur = '{mosi: 16'h0000, rises: 0, low_len: 0, first_fall: -1, period: -1, gap: high_run};
          word = {4'h0, adc_val[prev_addr]};
          fall_cnt = 0;
          rise1 = -1;
          bus.MISO = 1'b0;
        end
        cur.low_len++;
        if (prev_sclk && !bus.SCLK) begin
          if (cur.first_fall < 0) cur.first_fall = cur.low_len - 1;
          if (fall_cnt < 16) bus.MISO = word[15 - fall_cnt];
          fall_cnt++;
        end
        if (!prev_sclk && bus.SCLK) begin
          cur.mosi = {cur.mosi[14:0], bus.MOSI};
          cur.rises++;
          if (rise1 < 0) rise1 = cur.low_len - 1;
          else if (cur.period < 0) cur.period = cur.low_len - 1 - rise1;
        end
      end else begin
        if (!prev_ss) begin
          if (cur.rises == 16) prev_addr = cur.mosi[13:11];
          frames_q.push_back(cur);
          high_run = 0;
          bus.MISO = 1'b0;
        end
        high_run++;
        if (bus.SCLK !== 1'b1 || bus.MOSI !== 1'b0) idle_bad++;
      end
      prev_ss = bus.a2d_SS_n;
      prev_sclk = bus.SCLK;
    end
  end

  // Runs one conversion; called just after a negedge, returns on the negedge
  // where cnv_cmplt is first seen high.
  task automatic run_conv(input logic [2:0] ch, input logic [11:0] exp_res,
                          input logic [15:0] exp_mosi, input bit busy);
    int lat;
    frame_t f;
    frames_q.delete();
    bus.strt_cnv = 1'b1;
    bus.chnnl = ch;
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    bus.chnnl = ~ch;
    chk("cmplt_clear", 32'(bus.cnv_cmplt), 32'd0);
    chk("res_hold_e0", 32'(bus.res), 32'(model_res));
    lat = 0;
    for (int k = 1; k <= 1500 && lat == 0; k++) begin
      @(negedge clk);
      if (busy) begin
        bus.strt_cnv = (k == 99 || k == 699);
        if (k == 99 || k == 699) bus.chnnl = 3'd5;
      end
      if (k == 1088) chk("res_hold", 32'(bus.res), 32'(model_res));
      if (bus.cnv_cmplt) lat = k;
    end
    bus.strt_cnv = 1'b0;
    chk("latency", 32'(lat), 32'd1089);
    chk("res", 32'(bus.res), 32'(exp_res));
    model_res = exp_res;
    chk("frame_count", 32'(frames_q.size()), 32'd2);
    for (int i = 0; i < frames_q.size() && i < 2; i++) begin
      f = frames_q[i];
      chk("mosi_word", 32'(f.mosi), 32'(exp_mosi));
      chk("rises", 32'(f.rises), 32'd16);
      chk("ss_low_len", 32'(f.low_len), 32'd528);
      chk("first_fall", 32'(f.first_fall), 32'd16);
      chk("sclk_period", 32'(f.period), 32'd32);
      if (i == 1) chk("gap_len", 32'(f.gap), 32'd32);
    end
  endtask

  vec_t        tbl [24];
  logic [11:0] vals [3];
  logic [15:0] mosi_tab [8];
  logic [2:0]  rch;
  int          bad;

  initial begin
    vals = '{12'h000, 12'hFFF, 12'h800};
    mosi_tab = '{16'h0000, 16'h0800, 16'h1000, 16'h1800,
                 16'h2000, 16'h2800, 16'h3000, 16'h3800};
    for (int i = 0; i < 24; i++) begin
      tbl[i].ch = 3'(i % 8);
      tbl[i].val = vals[i / 8];
      tbl[i].exp_mosi = mosi_tab[i % 8];
      tbl[i].exp_res = vals[i / 8];
    end
    for (int c = 0; c < 8; c++) adc_val[c] = 12'h000;

    rst = 1'b1;
    bus.strt_cnv = 1'b0;
    bus.chnnl = 3'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ss_n", 32'(bus.a2d_SS_n), 32'd1);
    chk("rst_sclk", 32'(bus.SCLK), 32'd1);
    chk("rst_mosi", 32'(bus.MOSI), 32'd0);
    chk("rst_cmplt", 32'(bus.cnv_cmplt), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversion on channel 1
    adc_val[1] = 12'hA5C;
    run_conv(3'd1, 12'hA5C, 16'h0800, 1'b0);

    // Reset held 3 cycles in the middle of frame 1
    @(negedge clk);
    bus.strt_cnv = 1'b1;
    bus.chnnl = 3'd3;
    @(negedge clk);
    bus.strt_cnv = 1'b0;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ss_n", 32'(bus.a2d_SS_n), 32'd1);
    chk("midrst_sclk", 32'(bus.SCLK), 32'd1);
    chk("midrst_mosi", 32'(bus.MOSI), 32'd0);
    chk("midrst_cmplt", 32'(bus.cnv_cmplt), 32'd0);
    chk("midrst_res", 32'(bus.res), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_res = 12'h000;
    repeat (3) @(negedge clk);

    // Channel walk from the vector table
    for (int i = 0; i < 24; i++) begin
      adc_val[tbl[i].ch] = tbl[i].val;
      run_conv(tbl[i].ch, tbl[i].exp_res, tbl[i].exp_mosi, 1'b0);
      @(negedge clk);
    end

    // Busy ignore: extra starts at E100 and E700 must be dropped
    adc_val[2] = 12'h3B7;
    adc_val[5] = 12'hC48;
    run_conv(3'd2, 12'h3B7, 16'h1000, 1'b1);
    bad = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (!bus.cnv_cmplt || !bus.a2d_SS_n) bad++;
    end
    chk("busy_no_second_conv", 32'(bad), 32'd0);
    chk("busy_frame_count", 32'(frames_q.size()), 32'd2);

    // Back-to-back: new start on the cycle cnv_cmplt first rises
    adc_val[4] = 12'h5E1;
    adc_val[7] = 12'h9D2;
    run_conv(3'd4, 12'h5E1, 16'h2000, 1'b0);
    run_conv(3'd7, 12'h9D2, 16'h3800, 1'b0);
    @(negedge clk);

    // Random conversions against the ADC model
    for (int n = 0; n < 6; n++) begin
      for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
      rch = 3'($urandom_range(0, 7));
      run_conv(rch, adc_val[rch], {2'b00, rch, 11'h000}, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk("idle_sclk_high_mosi_low", 32'(idle_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
